fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC of the first fetch after reset (bits [1:0] treated as 0).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request, level-held.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 SHALL have port imem_ack  input  1  transaction completes in any cycle with imem_req=1 and imem_ack=1.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid in the completing cycle only.
REQ-008 SHALL have port redirect_valid  input  1  control-flow change (branch/jal/jalr) this cycle.
REQ-009 SHALL have port redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0.
REQ-010 SHALL have port halt  input  1  stop launching new fetches (driven from is_halted).
REQ-011 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port inst_ready  input  1  consumer accepts the head; pop = inst_valid and inst_ready.
REQ-013 SHALL have port inst  output  32  instruction at buffer head.
REQ-014 SHALL have port inst_pc  output  32  PC of the instruction at buffer head.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, inst} with an occupancy count of 0..2; inst_valid = (count != 0).
REQ-016 SHALL implement states IDLE (nothing outstanding), WAIT (request outstanding, response kept) and DISCARD (request outstanding, response dropped).
REQ-017 In IDLE, imem_req SHALL be (count < 2) and not halt, combinationally, with imem_addr = fetch_pc.
REQ-018 In IDLE with imem_req=1 and imem_ack=0, the FSM SHALL go to WAIT and latch the request address.
REQ-019 In WAIT and DISCARD, imem_req SHALL stay 1 with imem_addr equal to the latched address until imem_ack, regardless of halt or count.
REQ-020 On a completing cycle in IDLE or WAIT without redirect, the FSM SHALL push {fetch_pc, imem_rdata}, set fetch_pc = fetch_pc + 4 (mod 2^32) and go to IDLE.
REQ-021 On a completing cycle in DISCARD, the FSM SHALL drop imem_rdata and go to IDLE.
REQ-022 Push and pop SHALL be allowed in the same cycle, leaving count unchanged; a push SHALL never occur at count = 2.
REQ-023 There SHALL be no combinational path from imem_rdata or imem_ack to inst, inst_pc or inst_valid; fetched data appears the cycle after the ack.
REQ-024 With a zero-wait memory and inst_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-025 redirect_valid SHALL take priority over push and pop: the FIFO is flushed (inst_valid=0 next cycle) and fetch_pc is loaded with {redirect_pc[31:2],2'b00}.
REQ-026 A redirect with a request issued but not completing this cycle (IDLE+req+!ack, WAIT+!ack, DISCARD+!ack) SHALL lead to DISCARD.
REQ-027 A redirect in a completing cycle SHALL drop the data and lead to IDLE.
REQ-028 A redirect in IDLE with no request issued SHALL stay in IDLE.
REQ-029 A repeated redirect in DISCARD SHALL only update fetch_pc.
REQ-030 halt SHALL not cancel an outstanding request; its response is buffered normally.
REQ-031 halt SHALL not block pops.

Reset
REQ-032 While reset=0, the block SHALL asynchronously force: state=IDLE, fetch_pc=RESET_PC, latched address=0, count=0, FIFO contents=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-033 A reset asserted mid-transaction SHALL abandon the transaction; a late imem_ack after reset release in IDLE with imem_req=0 SHALL be ignored.

Verification
REQ-034 Reset release, zero-wait memory returning data = addr, inst_ready=1 -> imem_addr 0,4,8,...; inst_valid rises the cycle after the first ack with inst_pc=0, inst=0; then one instruction per cycle.
REQ-035 inst_ready=0 -> after acks for 0 and 4, imem_req=0 with count=2; raising inst_ready -> pops pc 0 then 4 and imem_req resumes at 8.
REQ-036 Ack latency 3, redirect_pc=0x100 while the request for 8 is in WAIT -> imem_addr holds 8 until ack, that data never appears, next request is 0x100, next inst_pc is 0x100.
REQ-037 FIFO full plus redirect_pc=0x103 -> inst_valid=0 next cycle and the next fetch address is 0x100.
REQ-038 RESET_PC=0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-039 reset driven low in WAIT with no clock edge -> imem_req=0 and inst_valid=0 immediately; after release the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 2-entry {pc, inst} buffer,
// redirect flush with discard of an in-flight response.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned DEPTH = 2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [1:0]       state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]  pc_q   [DEPTH];
   logic [XLEN-1:0]  pc_d   [DEPTH];
   logic [XLEN-1:0]  inst_q [DEPTH];
   logic [XLEN-1:0]  inst_d [DEPTH];

   logic             push;
   logic             pop;
   logic [CNT_W-1:0] cnt_pop;

   // Request generation, FSM transitions and FIFO update
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      count_d    = count_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      push       = 1'b0;
      cnt_pop    = count_q;
      imem_req   = 1'b0;
      imem_addr  = addr_q;

      // Reset gates the request so it drops immediately on assertion
      if (state_q == ST_IDLE) begin
         imem_req  = reset && (count_q != CNT_W'(DEPTH)) && !halt;
         imem_addr = fetch_pc_q;
      end else begin
         imem_req  = reset;
         imem_addr = addr_q;
      end

      pop = (count_q != '0) && inst_ready;

      case (state_q)
         ST_IDLE: begin
            if (imem_req && !imem_ack) begin
               addr_d  = fetch_pc_q;
               state_d = redirect_valid ? ST_DISCARD : ST_WAIT;
            end else if (imem_req && imem_ack && !redirect_valid) begin
               push = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_ack) begin
               state_d = ST_IDLE;
               push    = !redirect_valid;
            end else if (redirect_valid) begin
               state_d = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (imem_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (redirect_valid) begin
         count_d    = '0;
         fetch_pc_d = redirect_pc & ALIGN_MASK;
      end else begin
         cnt_pop = count_q - CNT_W'(pop);
         if (pop) begin
            pc_d[0]   = pc_q[1];
            inst_d[0] = inst_q[1];
         end
         if (push) begin
            pc_d[cnt_pop[0]]   = fetch_pc_q;
            inst_d[cnt_pop[0]] = imem_rdata;
            fetch_pc_d         = fetch_pc_q + XLEN'(4);
         end
         count_d = cnt_pop + CNT_W'(push);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC & ALIGN_MASK;
         addr_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
      end
   end

   assign inst_valid = (count_q != '0);
   assign inst       = inst_q[0];
   assign inst_pc    = pc_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model (queue + outstanding request).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid, halt, inst_ready;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst, inst_pc;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_inst, w_inst_pc;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
   endfunction

   assign imem_rdata = mem(imem_addr);
   assign w_rdata    = mem(w_addr);

   fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   // Wrap-around instance: free-running zero-wait memory, always ready
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .reset(reset),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
      .inst_valid(w_valid), .inst_ready(1'b1), .inst(w_inst), .inst_pc(w_inst_pc)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [31:0] m_pc[$];
   logic [31:0] m_inst[$];
   logic [31:0] m_next_pc;
   logic [31:0] m_out_addr;
   bit          m_out;
   bit          m_keep;
   int          w_cnt = 0;

   task automatic model_reset();
      m_pc.delete();
      m_inst.delete();
      m_next_pc  = 32'h0;
      m_out      = 1'b0;
      m_keep     = 1'b0;
      m_out_addr = 32'h0;
   endtask

   // One clock: drive at posedge+1, check at negedge, advance the model
   task automatic cycle(input int pa, input int pr, input int pd, input int ph);
      bit          e_req, e_valid, pop, fire;
      logic [31:0] e_addr;
      imem_ack       = ($urandom_range(99) < pa);
      inst_ready     = ($urandom_range(99) < pr);
      redirect_valid = ($urandom_range(99) < pd);
      halt           = ($urandom_range(99) < ph);
      redirect_pc    = $urandom;
      #4;
      e_req   = m_out || ((m_pc.size() < 2) && !halt);
      e_addr  = m_out ? m_out_addr : m_next_pc;
      e_valid = (m_pc.size() != 0);
      check("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) check("imem_addr", imem_addr, e_addr);
      check("inst_valid", 32'(inst_valid), 32'(e_valid));
      if (e_valid) begin
         check("inst_pc", inst_pc, m_pc[0]);
         check("inst", inst, m_inst[0]);
      end
      if (w_cnt < 3) begin
         check("wrap_req", 32'(w_req), 32'h1);
         check("wrap_addr", w_addr, 32'hFFFF_FFF8 + 32'(w_cnt) * 32'd4);
         w_cnt++;
      end

      pop  = e_valid && inst_ready;
      fire = e_req && imem_ack;
      if (redirect_valid) begin
         m_pc.delete();
         m_inst.delete();
         if (fire) m_out = 1'b0;
         else if (e_req) begin
            m_out      = 1'b1;
            m_keep     = 1'b0;
            m_out_addr = e_addr;
         end
         m_next_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (pop) begin
            void'(m_pc.pop_front());
            void'(m_inst.pop_front());
         end
         if (fire) begin
            if (!m_out || m_keep) begin
               m_pc.push_back(e_addr);
               m_inst.push_back(mem(e_addr));
               m_next_pc = m_next_pc + 32'd4;
            end
            m_out = 1'b0;
         end else if (e_req && !m_out) begin
            m_out      = 1'b1;
            m_keep     = 1'b1;
            m_out_addr = e_addr;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b0;
      imem_ack       = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt           = 1'b0;
      model_reset();
      #12;
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_wrap_req", 32'(w_req), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Zero-wait streaming
      for (int i = 0; i < 20; i++) cycle(100, 100, 0, 0);
      // Stall consumer until full, then drain
      for (int i = 0; i < 6; i++) cycle(100, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(100, 100, 0, 0);

      // Leave a request outstanding, then reset mid-cycle with no clock edge
      cycle(0, 0, 0, 0);
      imem_ack       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_req", 32'(imem_req), 32'h0);
      check("async_rst_valid", 32'(inst_valid), 32'h0);
      imem_ack = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 300; i++) cycle(40, 70, 8, 0);
      for (int i = 0; i < 300; i++) cycle(60, 50, 10, 15);
      for (int i = 0; i < 300; i++) cycle(30, 80, 15, 30);
      for (int i = 0; i < 200; i++) cycle(100, 100, 5, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
